crc_decode: RTL and testbench

CRC_DECODE -- requirements
Module: crc_decode

---
 rtl/crc_decode_if.sv | 30 +++
 rtl/crc_decode.sv | 128 ++++++++++++
 tb/tb_crc_decode.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_decode_if.sv
// Bus bundle for the serial CRC decoder: bit-stream input side and
// stripped-payload / packet-status output side.
//
// Qualifier semantics: inb is meaningful only in cycles where in_valid and
// recving are both high; there is no backpressure, so the producer never waits.
// outb is meaningful only in cycles where out_valid is high, and the consumer
// must take it in that same cycle.
interface crc_decode_if;
    logic inb;
    logic in_valid;
    logic recving;
    logic pkttype;
    logic abort;
    logic outb;
    logic out_valid;
    logic done;
    logic crc_ok;
    logic crc_err;
    logic len_err;

    modport master (
        output inb, in_valid, recving, pkttype, abort,
        input  outb, out_valid, done, crc_ok, crc_err, len_err
    );

    modport slave (
        input  inb, in_valid, recving, pkttype, abort,
        output outb, out_valid, done, crc_ok, crc_err, len_err
    );
endinterface

// File: rtl/crc_decode.sv
// Serial CRC5/CRC16 packet checker. It strips the trailing CRC from the
// payload through a 16-bit delay line and reports the packet status at the
// end of the packet window.
module crc_decode (
    input  logic               clk,
    input  logic               rst_L,
    crc_decode_if.slave        bus,
    output logic [0:0]         dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q;
    logic        crc_type_q;
    logic [15:0] crc_q;
    logic [4:0]  cnt_q;
    logic [15:0] dl_q;
    logic        outb_q;
    logic        out_valid_q;
    logic        done_q;
    logic        crc_ok_q;
    logic        crc_err_q;
    logic        len_err_q;

    logic [15:0] crc_src;
    logic        type_sel;
    logic [15:0] crc_d;
    logic [4:0]  cnt_d;
    logic [15:0] dl_d;
    logic        enough_bits;
    logic        dl_tap;
    logic        long_enough;
    logic        res_match;

    // One LFSR step; the CRC5 form keeps the unused upper bits at zero.
    function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b,
                                             input logic is16);
        logic [15:0] nxt;
        logic        fb;
        if (is16) begin
            fb  = r[15] ^ b;
            nxt = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end else begin
            fb  = r[4] ^ b;
            nxt = {11'b0, r[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
        end
        return nxt;
    endfunction

    // Next-value logic: the start bit shifts into an all-ones register.
    always_comb begin
        crc_src     = (state_q == IDLE) ? 16'hFFFF : crc_q;
        type_sel    = (state_q == IDLE) ? bus.pkttype : crc_type_q;
        crc_d       = crc_step(crc_src, bus.inb, type_sel);
        cnt_d       = (cnt_q >= 5'd17) ? 5'd17 : cnt_q + 5'd1;
        dl_d        = {dl_q[14:0], bus.inb};
        enough_bits = crc_type_q ? (cnt_q >= 5'd16) : (cnt_q >= 5'd5);
        dl_tap      = crc_type_q ? dl_q[15] : dl_q[4];
        long_enough = crc_type_q ? (cnt_q > 5'd16) : (cnt_q > 5'd5);
        res_match   = crc_type_q ? (crc_q == 16'h800D) : (crc_q[4:0] == 5'b01100);
    end

    // Packet FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= IDLE;
            crc_type_q  <= 1'b0;
            crc_q       <= 16'hFFFF;
            cnt_q       <= 5'd0;
            dl_q        <= 16'h0000;
            outb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.recving && bus.in_valid && !bus.abort) begin
                        state_q    <= RECV;
                        crc_type_q <= bus.pkttype;
                        crc_q      <= crc_d;
                        cnt_q      <= 5'd1;
                        dl_q       <= dl_d;
                        crc_ok_q   <= 1'b0;
                        crc_err_q  <= 1'b0;
                        len_err_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (!bus.recving) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        crc_ok_q  <= long_enough & res_match;
                        crc_err_q <= ~(long_enough & res_match);
                        len_err_q <= ~long_enough;
                    end else if (bus.in_valid) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        dl_q  <= dl_d;
                        if (enough_bits) begin
                            out_valid_q <= 1'b1;
                            outb_q      <= dl_tap;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.outb      = outb_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.len_err   = len_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_crc_decode.sv
// Directed bench for crc_decode: a polynomial long-division model supplies
// expected payload bits and packet status; a negedge monitor compares them.
module tb_crc_decode;

    typedef struct packed {
        logic ok;
        logic err;
        logic len;
    } stat_t;

    logic       clk = 1'b0;
    logic       rst_L;
    logic [0:0] dbg_state;

    crc_decode_if bus();

    crc_decode dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         done_cnt = 0;
    int         out_cnt  = 0;
    logic [0:0] exp_q[$];
    stat_t      stat_q[$];
    stat_t      flags_exp = '0;
    stat_t      cur_stat;
    logic       pkt[64];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver remainder as (ones * x^n + M(x) * x^N) mod G(x), by long division.
    function automatic logic [15:0] model_crc(input int n, input logic ptype);
        logic        a[80];
        int          nn;
        logic [16:0] g;
        logic [15:0] rem;
        nn  = ptype ? 16 : 5;
        g   = ptype ? 17'h18005 : 17'h00025;
        rem = '0;
        for (int k = 0; k < n + nn; k++) a[k] = (k < n) ? pkt[k] : 1'b0;
        for (int k = 0; k < nn; k++) a[k] = ~a[k];
        for (int k = 0; k < n; k++)
            if (a[k])
                for (int j = 0; j <= nn; j++) a[k + j] = a[k + j] ^ g[nn - j];
        for (int j = 0; j < nn; j++) rem = {rem[14:0], a[n + j]};
        return rem;
    endfunction

    // Monitor: payload bits against the expected queue, status on done,
    // held flags on every other cycle.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) check("unexpected_out_valid", bus.out_valid, 0);
            else check("outb", bus.outb, exp_q.pop_front());
        end
        if (bus.done) begin
            done_cnt++;
            if (stat_q.size() == 0) begin
                check("unexpected_done", bus.done, 0);
            end else begin
                cur_stat = stat_q.pop_front();
                check("crc_ok", bus.crc_ok, cur_stat.ok);
                check("crc_err", bus.crc_err, cur_stat.err);
                check("len_err", bus.len_err, cur_stat.len);
                flags_exp = cur_stat;
            end
        end else begin
            check("held_flags", {bus.crc_ok, bus.crc_err, bus.len_err}, flags_exp);
        end
    end

    task automatic load_028(input logic flip3);
        for (int i = 0; i < 16; i++) pkt[i] = 1'b0;
        pkt[12] = 1'b1;
        if (flip3) pkt[3] = 1'b1;
    endtask

    // Drives one packet; -1 disables st1/st2/abort_at/rst_at.
    task automatic run_pkt(input string name, input int n, input logic ptype,
                           input int st1, input int st2, input int abort_at,
                           input int rst_at, input int gap, input int exp_outs);
        int          nn;
        int          nexp;
        int          done0;
        int          out0;
        logic [15:0] rem;
        stat_t       s;
        nn = ptype ? 16 : 5;
        if (abort_at >= 0) nexp = abort_at + 1 - nn;
        else if (rst_at >= 0) nexp = rst_at - nn;
        else nexp = n - nn;
        if (nexp < 0) nexp = 0;
        check({name, "_model_outs"}, nexp, exp_outs);
        for (int i = 0; i < nexp; i++) exp_q.push_back(pkt[i]);
        if (abort_at < 0 && rst_at < 0) begin
            rem   = model_crc(n, ptype);
            s.ok  = (n > nn) && (rem == (ptype ? 16'h800D : 16'h000C));
            s.err = ~s.ok;
            s.len = (n <= nn);
            stat_q.push_back(s);
        end
        done0 = done_cnt;
        out0  = out_cnt;
        for (int i = 0; i < n; i++) begin
            bus.recving  = 1'b1;
            bus.in_valid = 1'b1;
            bus.inb      = pkt[i];
            bus.pkttype  = ptype;
            tick();
            if (i == 0) begin
                flags_exp = '0;
                done0     = done_cnt;
                out0      = out_cnt;
            end
            if (i == rst_at) begin
                rst_L        = 1'b0;
                bus.recving  = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                check({name, "_rst_outputs"},
                      {bus.outb, bus.out_valid, bus.done, bus.crc_ok, bus.crc_err, bus.len_err}, 0);
                check({name, "_rst_state"}, dbg_state, 0);
                repeat (2) tick();
                rst_L = 1'b1;
                bus.recving = 1'b1;
                repeat (2) tick();
                break;
            end
            if (i == abort_at) begin
                bus.inb   = 1'b1;
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                break;
            end
            if (i == st1 || i == st2) begin
                bus.in_valid = 1'b0;
                bus.inb      = 1'b1;
                repeat (3) tick();
            end
        end
        // Window closes; stray in_valid with recving low must be ignored.
        for (int g = 0; g < gap; g++) begin
            bus.recving  = 1'b0;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.inb      = 1'($urandom_range(0, 1));
            bus.pkttype  = 1'($urandom_range(0, 1));
            tick();
        end
        if (gap > 1) begin
            check({name, "_done_count"}, done_cnt - done0,
                  (abort_at < 0 && rst_at < 0) ? 1 : 0);
            check({name, "_out_count"}, out_cnt - out0, nexp);
            check({name, "_exp_left"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        rst_L        = 1'b0;
        bus.inb      = 1'b0;
        bus.in_valid = 1'b0;
        bus.recving  = 1'b0;
        bus.pkttype  = 1'b0;
        bus.abort    = 1'b0;
        #1;
        check("reset_outputs",
              {bus.outb, bus.out_valid, bus.done, bus.crc_ok, bus.crc_err, bus.len_err}, 0);
        check("reset_state", dbg_state, 0);
        repeat (3) tick();
        rst_L = 1'b1;
        tick();

        // Hand-computed pins on the model itself.
        load_028(1'b0);
        check("pin_crc5_good", model_crc(16, 1'b0), 16'h000C);
        load_028(1'b1);
        check("pin_crc5_bad_differs", int'(model_crc(16, 1'b0) == 16'h000C), 0);
        for (int i = 0; i < 16; i++) pkt[i] = 1'b0;
        check("pin_crc16_empty", model_crc(16, 1'b1), 16'h800D);

        load_028(1'b0);
        run_pkt("crc5_good", 16, 1'b0, -1, -1, -1, -1, 4, 11);
        check("crc5_good_ok_literal", {bus.crc_ok, bus.crc_err, bus.len_err}, 3'b100);
        load_028(1'b1);
        run_pkt("crc5_err", 16, 1'b0, -1, -1, -1, -1, 4, 11);
        check("crc5_err_literal", {bus.crc_ok, bus.crc_err, bus.len_err}, 3'b010);
        for (int i = 0; i < 16; i++) pkt[i] = 1'b0;
        run_pkt("crc16_zero_len", 16, 1'b1, -1, -1, -1, -1, 4, 0);
        load_028(1'b0);
        run_pkt("crc5_stall", 16, 1'b0, 2, 9, -1, -1, 4, 11);
        check("crc5_stall_ok_literal", bus.crc_ok, 1);
        for (int i = 0; i < 3; i++) pkt[i] = 1'b1;
        run_pkt("crc5_short", 3, 1'b0, -1, -1, -1, -1, 4, 0);
        check("crc5_short_literal", {bus.crc_err, bus.len_err}, 2'b11);
        load_028(1'b0);
        pkt[5] = 1'b1;
        pkt[7] = 1'b1;
        run_pkt("abort", 16, 1'b0, -1, -1, 7, -1, 4, 3);
        check("abort_flags", {bus.crc_ok, bus.crc_err, bus.len_err}, 0);
        load_028(1'b0);
        run_pkt("mid_reset", 16, 1'b0, -1, -1, -1, 5, 4, 0);
        load_028(1'b0);
        run_pkt("after_reset", 16, 1'b0, -1, -1, -1, -1, 4, 11);
        check("after_reset_ok_literal", bus.crc_ok, 1);

        // Back-to-back: next packet starts in the done cycle.
        load_028(1'b0);
        run_pkt("b2b_first", 16, 1'b0, -1, -1, -1, -1, 1, 11);
        load_028(1'b1);
        run_pkt("b2b_second", 16, 1'b0, -1, -1, -1, -1, 4, 11);

        // CRC16 path with a long random payload; count saturates.
        for (int i = 0; i < 20; i++) pkt[i] = 1'($urandom_range(0, 1));
        run_pkt("crc16_rand", 20, 1'b1, 4, -1, -1, -1, 4, 4);

        check("stat_left", stat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
